// File: rtl/conv_acc_stage_pkg.sv
// Shared constants for the convolution output path: CSA tree, accumulate stage and benches agree on these.
package conv_acc_stage_pkg;

  localparam int CONV_NBITS    = 16;
  localparam int CONV_N_CH     = 4;
  localparam int CONV_SHIFT    = 4;
  localparam int CONV_OUT_BITS = 8;
  localparam int CONV_NPIX     = 16;

  // Bias plus N_CH partial sums cannot overflow this width.
  function automatic int acc_bits(input int nbits, input int n_ch);
    return nbits + $clog2(n_ch + 1);
  endfunction

  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CONV_ACC_BITS = acc_bits(CONV_NBITS, CONV_N_CH);

endpackage

// File: rtl/conv_acc_stage_relu_round_sat.sv
// Combinational ReLU, round-half-up right shift and unsigned saturation of a signed accumulator.
// Zero latency; no flow control.
module conv_acc_stage_relu_round_sat #(
  parameter int IN_BITS  = 19,
  parameter int SHIFT    = 4,
  parameter int OUT_BITS = 8
) (
  input  logic signed [IN_BITS-1:0]  i_acc,
  output logic        [OUT_BITS-1:0] o_pix,
  output logic                       o_sat
);

  localparam logic [IN_BITS:0] MAX_PIX = {{(IN_BITS + 1 - OUT_BITS){1'b0}}, {OUT_BITS{1'b1}}};

  logic [IN_BITS-1:0] w_pos;
  logic [IN_BITS:0]   w_rnd;

  assign w_pos = i_acc[IN_BITS-1] ? '0 : i_acc;

  // One extra bit keeps the rounding increment from wrapping.
  generate
    if (SHIFT > 0) begin : g_round
      localparam logic [IN_BITS:0] HALF = (IN_BITS + 1)'(1) << (SHIFT - 1);
      logic [IN_BITS:0] w_sum;
      assign w_sum = {1'b0, w_pos} + HALF;
      assign w_rnd = w_sum >> SHIFT;
    end else begin : g_noround
      assign w_rnd = {1'b0, w_pos};
    end
  endgenerate

  assign o_sat = (w_rnd > MAX_PIX);
  assign o_pix = o_sat ? {OUT_BITS{1'b1}} : w_rnd[OUT_BITS-1:0];

endmodule

// File: rtl/conv_acc_stage.sv
// Accumulates N_CH partial sums plus bias into one pixel, then ReLU/round/saturate into a one-entry output register.
// Pixel visible one cycle after the last-channel handshake; only the last channel is refused while the output is stalled.
module conv_acc_stage
  import conv_acc_stage_pkg::*;
#(
  parameter int NBITS    = CONV_NBITS,
  parameter int N_CH     = CONV_N_CH,
  parameter int SHIFT    = CONV_SHIFT,
  parameter int OUT_BITS = CONV_OUT_BITS,
  parameter int NPIX     = CONV_NPIX
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic signed [NBITS-1:0]    psum_i,
  input  logic signed [NBITS-1:0]    bias_i,
  input  logic                       psum_valid_i,
  output logic                       psum_ready_o,
  output logic        [OUT_BITS-1:0] pix_o,
  output logic                       pix_valid_o,
  input  logic                       pix_ready_i,
  output logic                       sat_o,
  output logic                       frame_done_o
);

  localparam int ACC_BITS = acc_bits(NBITS, N_CH);
  localparam int CH_W     = cnt_bits(N_CH);
  localparam int PIX_W    = cnt_bits(NPIX);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);

  logic        [CH_W-1:0]     r_ch_cnt;
  logic signed [ACC_BITS-1:0] r_acc;
  logic        [PIX_W-1:0]    r_pix_cnt;
  logic        [OUT_BITS-1:0] r_pix;
  logic                       r_pix_valid;
  logic                       r_sat;

  logic                       w_first;
  logic                       w_last;
  logic                       w_in_hs;
  logic                       w_out_hs;
  logic signed [ACC_BITS-1:0] w_psum_ext;
  logic signed [ACC_BITS-1:0] w_bias_ext;
  logic signed [ACC_BITS-1:0] w_acc_base;
  logic signed [ACC_BITS-1:0] w_acc_next;
  logic        [OUT_BITS-1:0] w_pix;
  logic                       w_sat;

  assign w_first    = (r_ch_cnt == '0);
  assign w_last     = (r_ch_cnt == CH_LAST);
  assign w_psum_ext = {{(ACC_BITS - NBITS){psum_i[NBITS-1]}}, psum_i};
  assign w_bias_ext = {{(ACC_BITS - NBITS){bias_i[NBITS-1]}}, bias_i};
  assign w_acc_base = w_first ? w_bias_ext : r_acc;
  assign w_acc_next = w_acc_base + w_psum_ext;

  // Only the pixel-completing channel has to wait for the output slot.
  assign psum_ready_o = !(w_last && r_pix_valid && !pix_ready_i);
  assign w_in_hs      = psum_valid_i && psum_ready_o;
  assign w_out_hs     = r_pix_valid && pix_ready_i;

  conv_acc_stage_relu_round_sat #(
    .IN_BITS  (ACC_BITS),
    .SHIFT    (SHIFT),
    .OUT_BITS (OUT_BITS)
  ) u_relu_round_sat (
    .i_acc (w_acc_next),
    .o_pix (w_pix),
    .o_sat (w_sat)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ch_cnt    <= '0;
      r_acc       <= '0;
      r_pix_cnt   <= '0;
      r_pix       <= '0;
      r_pix_valid <= 1'b0;
      r_sat       <= 1'b0;
    end else begin
      if (w_in_hs) begin
        r_acc    <= w_acc_next;
        r_ch_cnt <= w_last ? '0 : r_ch_cnt + CH_W'(1);
      end
      // A new result overrides the drain so back-to-back pixels keep full rate.
      if (w_in_hs && w_last) begin
        r_pix       <= w_pix;
        r_pix_valid <= 1'b1;
        if (w_sat) begin
          r_sat <= 1'b1;
        end
      end else if (w_out_hs) begin
        r_pix_valid <= 1'b0;
      end
      if (w_out_hs) begin
        r_pix_cnt <= (r_pix_cnt == PIX_LAST) ? '0 : r_pix_cnt + PIX_W'(1);
      end
    end
  end

  assign pix_o        = r_pix;
  assign pix_valid_o  = r_pix_valid;
  assign sat_o        = r_sat;
  assign frame_done_o = w_out_hs && (r_pix_cnt == PIX_LAST);

endmodule

// File: doc/conv_acc_stage.md
Name: conv_acc_stage

Overview:
- Output stage that directly consumes the CSA-tree result (one kernel-window sum per cycle) in the convolution datapath.
- Accumulates N_CH per-channel partial sums into one output pixel and adds a bias.
- Applies ReLU, rounding right-shift and unsigned saturation to OUT_BITS.
- Delivers pixels over a valid/ready handshake with a single-entry output register, and flags frame completion.

Parameters:
- NBITS, packConv::NBITS, width of incoming partial sum and bias (signed two's complement)
- N_CH, 4, partial sums accumulated per output pixel (>=1)
- SHIFT, 4, arithmetic right-shift applied after ReLU (0 = no shift, no rounding)
- OUT_BITS, 8, unsigned output pixel width
- NPIX, 16, output pixels per frame (>=1)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low reset
- psum_i  in  NBITS  signed partial sum from CSA tree
- bias_i  in  NBITS  signed bias; sampled only on the first-channel handshake of each pixel
- psum_valid_i  in  1  psum_i/bias_i valid
- psum_ready_o  out  1  stage accepts psum_i this cycle
- pix_o  out  OUT_BITS  unsigned output pixel
- pix_valid_o  out  1  pix_o valid
- pix_ready_i  in  1  downstream accepts pix_o
- sat_o  out  1  sticky: some pixel saturated since reset
- frame_done_o  out  1  one-cycle pulse on handshake of the NPIX-th pixel

Behaviour:
Interface:
- One clock; reset is synchronous and active-low.
- Reset (reset=0 at a rising edge) forces: ch_cnt=0, acc=0, pix_cnt=0, pix_valid_o=0, pix_o=0, sat_o=0, frame_done_o=0.
- Reset asserted mid-pixel discards the partial accumulation and any held output.

Accumulator arithmetic:
- Width ACC_BITS = NBITS + $clog2(N_CH+1); signed; never overflows.
- Input handshake: psum_valid_i && psum_ready_o.
- On input handshake with ch_cnt==0: acc <= sext(bias_i) + sext(psum_i).
- On input handshake with ch_cnt>0: acc <= acc + sext(psum_i).
- ch_cnt increments on each handshake and wraps to 0 after N_CH-1.

Last-channel handshake (ch_cnt==N_CH-1), with total = acc_next:
- r = (total<0) ? 0 : total.
- If SHIFT>0: r = (r + 2^(SHIFT-1)) >>> SHIFT.
- If r > 2^OUT_BITS-1: pix_o <= 2^OUT_BITS-1 and sat_o <= 1; otherwise pix_o <= r[OUT_BITS-1:0].
- pix_valid_o <= 1.
- Latency: pixel visible the cycle after the last-channel handshake.

Flow control:
- psum_ready_o = !(ch_cnt==N_CH-1 && pix_valid_o && !pix_ready_i). Combinational; does not depend on psum_valid_i.
- Non-last channels are accepted even while the output is stalled.
- Output handshake (pix_valid_o && pix_ready_i) with no simultaneous new result: pix_valid_o <= 0.
- Output handshake in the same cycle as a last-channel handshake: new pixel loads and pix_valid_o stays 1. This gives full throughput of one pixel per N_CH cycles.
- pix_o and pix_valid_o are held stable while pix_valid_o && !pix_ready_i.

Frame counting:
- pix_cnt increments on each output handshake.
- At NPIX-1, that handshake raises frame_done_o for exactly one cycle and wraps pix_cnt to 0.
- sat_o clears only on reset.

States (implicit FSM in ch_cnt and pix_valid_o):
- ACCUM: ch_cnt < N_CH-1.
- LAST: ch_cnt == N_CH-1, output free.
- STALL: LAST with output held and pix_ready_i=0.
- STALL -> LAST when pix_ready_i=1.

N_CH==1 special case: every handshake is both first and last channel.

Decomposition:
- packConv gains ACC_BITS-style localparams only if shared. N_CH, OUT_BITS and NPIX become package constants so the CSA, acc stage and testbench agree.
- One sub-module is natural: relu_round_sat (combinational: signed ACC_BITS in -> OUT_BITS out + sat flag). It is reused by other output stages.

Test Plan:
All scenarios use NBITS=16, N_CH=4, SHIFT=4, OUT_BITS=8, NPIX=16, pix_ready_i=1 unless stated.
- Basic: bias 8, psums 10,20,30,40 back-to-back -> total 108; pix_o=7 ((108+8)>>4) one cycle after 4th handshake; sat_o=0.
- ReLU: bias 0, psums -100,10,10,10 -> total -70; pix_o=0; sat_o=0.
- Saturation: bias 0, psums 2000 x4 -> 8000 -> 500 after shift; pix_o=255, sat_o=1 and stays 1 across later normal pixels.
- Backpressure: pix_ready_i=0 after the first pixel completes.
  - Next pixel's channels 0..2 are accepted; psum_ready_o=0 at channel 3 and pix_o is held.
  - Raising pix_ready_i gives that cycle: old pixel handshakes, channel 3 is accepted, new pixel valid the next cycle.
- Frame: stream 16 pixels with random pix_ready_i -> exactly one frame_done_o pulse, coincident with the 16th output handshake; 17th pixel starts a new count.
- Reset mid-pixel: after 2 channels, drive reset=0 for one cycle -> pix_valid_o=0, sat_o=0.
  - Next 4 psums (bias 0, 16 each) yield pix_o=4 with no carry-over from the discarded accumulation.
